// File: rtl/denise_bitplane_shifter.sv
// Bitplane parallel-to-serial shifter with 0..255 x 35 ns scroll delay; shres mode needs DENISE_SHIFTER_SHRES_EN.
// Latency: lores/scroll=0/16b fetch puts data_in[63] on out 5 clks after the load edge; each scroll step adds 1 clk.
// Backpressure: none; load is sampled only in the c1=0,c3=0 phase and other loads are dropped.
module denise_bitplane_shifter (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        clk7_en,
    input  logic        c1,
    input  logic        c3,
    input  logic        load,
    input  logic        hires,
    input  logic        shres,
    input  logic [1:0]  fmode,
    input  logic        aga,
    input  logic [63:0] data_in,
    input  logic [7:0]  scroll,
    output logic        out
);

    logic [63:0] shifter_q, shifter_d;
    logic [63:0] scroller_q, scroller_d;
    logic [7:0]  slave_q, slave_d;
    logic [1:0]  fm;
    logic [5:0]  mask;
    logic [5:0]  select;
    logic [2:0]  fine_sel;
    logic        shift_en;
    logic        scr_out;
    logic        unused_inputs;

`ifdef DENISE_SHIFTER_SHRES_EN
    assign unused_inputs = clk7_en;
`else
    assign unused_inputs = clk7_en ^ shres;
`endif

    always_comb begin
        fm = aga ? fmode : 2'b00;
        case (fm)
            2'b00:   mask = 6'h0F;
            2'b11:   mask = 6'h3F;
            default: mask = 6'h1F;
        endcase
        // Coarse delay picks a scroller tap; the low scroll bits become the fine slave tap.
        if (hires) begin
            shift_en = ~c1 ^ c3;
            select   = scroll[6:1] & mask;
            fine_sel = {1'b1, scroll[0], 1'b1};
        end else begin
            shift_en = ~c1 & ~c3;
            select   = scroll[7:2] & mask;
            fine_sel = {1'b0, scroll[1:0]};
        end
`ifdef DENISE_SHIFTER_SHRES_EN
        if (shres) begin
            shift_en = 1'b1;
            select   = scroll[5:0] & mask;
            fine_sel = 3'b011;
        end
`endif
    end

    assign scr_out = scroller_q[select];
    assign out     = slave_q[fine_sel];

    always_comb begin
        shifter_d  = shifter_q;
        scroller_d = scroller_q;
        if (load && !c1 && !c3) begin
            shifter_d = data_in;
        end else if (shift_en) begin
            shifter_d = {shifter_q[62:0], 1'b0};
        end
        if (shift_en) begin
            scroller_d = {scroller_q[62:0], shifter_q[63]};
        end
        slave_d = {slave_q[6:0], scr_out};
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            shifter_q  <= 64'd0;
            scroller_q <= 64'd0;
            slave_q    <= 8'd0;
        end else begin
            shifter_q  <= shifter_d;
            scroller_q <= scroller_d;
            slave_q    <= slave_d;
        end
    end

endmodule

// File: tb/tb_denise_bitplane_shifter.sv
// Bench for denise_bitplane_shifter: directed timing pulses plus random traffic against a queue-based reference.
// Honours DENISE_SHIFTER_SHRES_EN the same way the design does.
module tb_denise_bitplane_shifter;

    logic        clk = 1'b0;
    logic        reset_n = 1'b1;
    logic        clk7_en = 1'b0;
    logic        c1 = 1'b0;
    logic        c3 = 1'b0;
    logic        load = 1'b0;
    logic        hires = 1'b0;
    logic        shres = 1'b0;
    logic [1:0]  fmode = 2'b00;
    logic        aga = 1'b0;
    logic [63:0] data_in = 64'd0;
    logic [7:0]  scroll = 8'd0;
    logic        out;

    int n_cmp = 0;
    int n_bad = 0;
    int phase = 0;

    // Reference state: pending fetch bits (front = next out), emitted bits (front = newest),
    // and the per-clock history of the tapped stream (front = newest).
    bit m_sh[$];
    bit m_em[$];
    bit m_so[$];

    denise_bitplane_shifter dut (
        .clk     (clk),
        .reset_n (reset_n),
        .clk7_en (clk7_en),
        .c1      (c1),
        .c3      (c3),
        .load    (load),
        .hires   (hires),
        .shres   (shres),
        .fmode   (fmode),
        .aga     (aga),
        .data_in (data_in),
        .scroll  (scroll),
        .out     (out)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp_v);
        n_cmp++;
        if (obs !== exp_v) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp_v);
        end
    endtask

    function automatic bit m_shres();
`ifdef DENISE_SHIFTER_SHRES_EN
        return shres;
`else
        return 1'b0;
`endif
    endfunction

    task automatic model_reset();
        m_sh = {};
        m_em = {};
        m_so = {};
        for (int i = 0; i < 64; i++) begin
            m_sh.push_back(1'b0);
            m_em.push_back(1'b0);
        end
        for (int i = 0; i < 8; i++) m_so.push_back(1'b0);
    endtask

    task automatic model_edge();
        bit shr;
        bit en;
        bit sc;
        int depth;
        int sel;
        shr = m_shres();
        en  = shr || (hires ? (c1 == c3) : (!c1 && !c3));
        if (!aga || fmode == 2'b00) depth = 16;
        else if (fmode == 2'b11)    depth = 64;
        else                        depth = 32;
        sel = (shr ? int'(scroll) : hires ? int'(scroll) / 2 : int'(scroll) / 4) % depth;
        sc = m_em[sel];
        m_so.push_front(sc);
        void'(m_so.pop_back());
        if (en) begin
            m_em.push_front(m_sh[0]);
            void'(m_em.pop_back());
        end
        if (load && !c1 && !c3) begin
            for (int i = 0; i < 64; i++) m_sh[i] = data_in[63 - i];
        end else if (en) begin
            void'(m_sh.pop_front());
            m_sh.push_back(1'b0);
        end
    endtask

    function automatic bit model_out();
        int fine;
        if (m_shres()) fine = 3;
        else if (hires) fine = 5 + 2 * int'(scroll[0]);
        else fine = int'(scroll) % 4;
        return m_so[fine];
    endfunction

    // Drives one 28 MHz cycle in phase order (c1,c3) = 00,01,11,10 and checks out after the edge.
    task automatic step(input logic ld);
        c1      = (phase == 2) || (phase == 3);
        c3      = (phase == 1) || (phase == 2);
        clk7_en = (phase == 0);
        load    = ld;
        @(posedge clk);
        model_edge();
        phase = (phase + 1) % 4;
        #1;
        chk("out", out, model_out());
    endtask

    task automatic do_reset(input logic keep_load);
        #2;
        reset_n = 1'b0;
        load    = keep_load;
        #1;
        chk("rst_out", out, 0);
        chk("rst_shifter", dut.shifter_q, 0);
        chk("rst_scroller", dut.scroller_q, 0);
        chk("rst_slave", dut.slave_q, 0);
        @(posedge clk);
        #1;
        chk("rst_hold_out", out, 0);
        chk("rst_hold_shifter", dut.shifter_q, 0);
        model_reset();
        phase = 0;
        load  = 1'b0;
        @(negedge clk);
        reset_n = 1'b1;
        #1;
    endtask

    function automatic logic [127:0] pulse(input int first, input int width);
        logic [127:0] v;
        v = '0;
        for (int i = first; i < first + width; i++) v[i] = 1'b1;
        return v;
    endfunction

    // Loads d on edge 0, records out after edges 1..n and compares against expected bit map.
    task automatic dir_test(input string tag, input logic hi, input logic shr, input logic ag,
                            input logic [1:0] fm, input logic [7:0] scr, input logic [63:0] d,
                            input logic bad_ld, input logic [127:0] exp_v, input int n);
        logic [127:0] rec;
        rec = '0;
        do_reset(1'b0);
        hires   = hi;
        shres   = shr;
        aga     = ag;
        fmode   = fm;
        scroll  = scr;
        data_in = d;
        step(1'b1);
        for (int k = 1; k <= n; k++) begin
            logic ld;
            ld = bad_ld && (k % 4 == 2);
            data_in = ld ? 64'hFFFF_FFFF_FFFF_FFFF : 64'd0;
            step(ld);
            rec[k] = out;
        end
        chk(tag, rec, exp_v);
    endtask

    initial begin
        model_reset();
        do_reset(1'b0);

        for (int s = 0; s <= 4; s++) begin
            dir_test($sformatf("lores_scroll%0d", s), 1'b0, 1'b0, 1'b0, 2'b00, 8'(s),
                     64'h8000_0000_0000_0000, 1'b0, pulse(5 + s, 4), 20);
        end
        dir_test("hires_a000", 1'b1, 1'b0, 1'b0, 2'b00, 8'h00, 64'hA000_0000_0000_0000,
                 1'b0, pulse(8, 2) | pulse(12, 2), 20);
        dir_test("mask_ocs_fm11", 1'b0, 1'b0, 1'b0, 2'b11, 8'h40, 64'h8000_0000_0000_0000,
                 1'b0, pulse(5, 4), 20);
        dir_test("aga_fm11_scroll40", 1'b0, 1'b0, 1'b1, 2'b11, 8'h40, 64'h8000_0000_0000_0000,
                 1'b0, pulse(69, 4), 80);
        dir_test("load_c1_ignored", 1'b0, 1'b0, 1'b0, 2'b00, 8'h00, 64'h8000_0000_0000_0000,
                 1'b1, pulse(5, 4), 20);
`ifdef DENISE_SHIFTER_SHRES_EN
        dir_test("shres_scroll0", 1'b0, 1'b1, 1'b1, 2'b11, 8'h00, 64'h8000_0000_0000_0000,
                 1'b0, pulse(5, 1), 80);
        dir_test("shres_scroll3f", 1'b0, 1'b1, 1'b1, 2'b11, 8'h3F, 64'h8000_0000_0000_0000,
                 1'b0, pulse(68, 1), 80);
`else
        dir_test("shres_ignored", 1'b0, 1'b1, 1'b1, 2'b11, 8'h00, 64'h8000_0000_0000_0000,
                 1'b0, pulse(5, 4), 20);
`endif

        // Reset in the middle of an all-ones stream, with load held high.
        do_reset(1'b0);
        hires   = 1'b0;
        shres   = 1'b0;
        scroll  = 8'h00;
        data_in = 64'hFFFF_FFFF_FFFF_FFFF;
        step(1'b1);
        for (int k = 0; k < 10; k++) step(1'b0);
        do_reset(1'b1);

        // Random traffic with mid-line mode and scroll changes.
        for (int k = 0; k < 3000; k++) begin
            if ($urandom_range(0, 15) == 0) begin
                hires = 1'($urandom_range(0, 1));
                shres = ($urandom_range(0, 3) == 0);
                aga   = 1'($urandom_range(0, 1));
                fmode = 2'($urandom_range(0, 3));
            end
            if ($urandom_range(0, 7) == 0) scroll = 8'($urandom_range(0, 255));
            data_in = {$urandom, $urandom};
            step(1'($urandom_range(0, 1)));
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
